// File: rtl/if_stage_if.sv
// if_stage_if: IF <-> ID handshake and instruction-SRAM port bundle.
// master = the fetch stage, slave = its environment (ID stage plus SRAM).
interface if_stage_if;
  localparam int IF_TO_ID_BUS_WD   = 64;
  localparam int ID_TO_IF_BRBUS_WD = 33;

  logic                         id_allowin;
  logic                         if_to_id_valid;
  logic [IF_TO_ID_BUS_WD-1:0]   if_to_id_bus;     // {inst, pc}
  logic [ID_TO_IF_BRBUS_WD-1:0] id_to_if_brbus;   // {br_jmp, br_dst}
  logic                         inst_sram_en;
  logic [31:0]                  inst_sram_addr;
  logic [31:0]                  inst_sram_rdata;

  modport master (
    input  id_allowin, id_to_if_brbus, inst_sram_rdata,
    output if_to_id_valid, if_to_id_bus, inst_sram_en, inst_sram_addr
  );

  modport slave (
    output id_allowin, id_to_if_brbus, inst_sram_rdata,
    input  if_to_id_valid, if_to_id_bus, inst_sram_en, inst_sram_addr
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage RV32 pipeline.
// Generates the PC, drives a 1-cycle-latency instruction SRAM and hands
// {inst, pc} to ID over a valid/allowin handshake. A taken branch/jump from
// ID squashes the fall-through word held in IF and redirects fetch.
// Optional build macro IF_INST_BUF_EN: a one-entry buffer holds the stalled
// word so the SRAM is not re-read on every stall cycle.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         reset,   // asynchronous, active-low
  if_stage_if.master   bus
);

  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] seq_pc;

  logic        br_taken;
  logic [31:0] br_dst;
  logic        if_allowin;
  logic        advance;
  logic [31:0] next_pc;
  logic [31:0] inst;
  logic        fetch_en;

  assign br_taken   = bus.id_to_if_brbus[32];
  assign br_dst     = bus.id_to_if_brbus[31:0];
  assign if_allowin = !if_valid || bus.id_allowin;

  // Pick the fetch address: redirect wins, then sequential, else re-read.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch.
    next_pc = if_pc;
    advance = 1'b0;
    if (br_taken) begin
      next_pc = br_dst;
      advance = 1'b1;
    end else if (if_allowin) begin
      next_pc = seq_pc;
      advance = 1'b1;
    end
  end

  // PC state: load the requested address whenever IF moves on.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking for all state so every flop samples pre-edge values.
    if (!reset) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      seq_pc   <= RESET_PC;
    end else if (advance) begin
      if_valid <= 1'b1;
      if_pc    <= next_pc;
      seq_pc   <= next_pc + 32'd4;   // wraps modulo 2^32
    end
  end

`ifdef IF_INST_BUF_EN
  logic [31:0] inst_buf;
  logic        buf_valid;

  // Capture the stalled word once; release it on accept or redirect.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the buffer data is reset too, so the bus never shows X after reset.
    if (!reset) begin
      buf_valid <= 1'b0;
      inst_buf  <= 32'h0;
    end else if (br_taken || (bus.if_to_id_valid && bus.id_allowin)) begin
      buf_valid <= 1'b0;
    end else if (if_valid && !bus.id_allowin && !buf_valid) begin
      buf_valid <= 1'b1;
      inst_buf  <= bus.inst_sram_rdata;
    end
  end

  // The SRAM is idle only while the buffer covers a continuing stall; any
  // cycle that advances IF must issue its read.
  assign inst     = buf_valid ? inst_buf : bus.inst_sram_rdata;
  assign fetch_en = !(buf_valid && !advance);
`else
  assign inst     = bus.inst_sram_rdata;
  assign fetch_en = 1'b1;
`endif

  // Outputs are forced quiet while reset is held.
  assign bus.inst_sram_en   = reset && fetch_en;
  assign bus.inst_sram_addr = reset ? next_pc : 32'h0;
  assign bus.if_to_id_valid = reset && if_valid && !br_taken;
  assign bus.if_to_id_bus   = reset ? {inst, if_pc} : 64'h0;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan sequence with literal expectations, then
// randomized allowin/redirect/reset stimulus compared every cycle against a
// transaction-level model of the fetch stream.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  if_stage_if io();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (io)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // Synchronous instruction SRAM, 1-cycle read latency, holds when idle.
  always @(posedge clk)
    if (io.inst_sram_en) io.inst_sram_rdata <= mem_word(io.inst_sram_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // The model tracks the instruction held for ID (slot) and the next
  // sequential address; the buffer build idles the SRAM on the second and
  // later consecutive stall cycles.
  bit          m_full = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_next = RESET_PC;
  bit          m_prev_stall = 0;

  always @(negedge clk) begin
    bit          br, stall, exp_valid, exp_en, take_new;
    logic [31:0] dst, exp_addr;
    if (!reset) begin
      check("rst_en",    io.inst_sram_en,   1'b0);
      check("rst_addr",  io.inst_sram_addr, 32'h0);
      check("rst_valid", io.if_to_id_valid, 1'b0);
      check("rst_bus",   io.if_to_id_bus,   64'h0);
      m_full = 0; m_pc = '0; m_next = RESET_PC; m_prev_stall = 0;
    end else begin
      br        = io.id_to_if_brbus[32];
      dst       = io.id_to_if_brbus[31:0];
      take_new  = !m_full || io.id_allowin;
      exp_addr  = br ? dst : (take_new ? m_next : m_pc);
      exp_valid = m_full && !br;
      stall     = m_full && !io.id_allowin && !br;
`ifdef IF_INST_BUF_EN
      exp_en    = !(m_prev_stall && stall);
`else
      exp_en    = 1'b1;
`endif
      check("en", io.inst_sram_en, exp_en);
      if (exp_en) check("addr", io.inst_sram_addr, exp_addr);
      check("valid", io.if_to_id_valid, exp_valid);
      if (exp_valid) check("bus", io.if_to_id_bus, {mem_word(m_pc), m_pc});
      if (br) begin
        m_full = 1; m_pc = dst; m_next = dst + 32'd4;
      end else if (take_new) begin
        m_full = 1; m_pc = m_next; m_next = m_next + 32'd4;
      end
      m_prev_stall = stall;
    end
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of inputs just after the edge, return at the negedge.
  task automatic drive(input logic r, input logic a, input logic b, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset             = r;
    io.id_allowin     = a;
    io.id_to_if_brbus = {b, d};
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] pc,
                            input logic [31:0] addr);
    check({name, "_valid"}, io.if_to_id_valid, v);
    if (v) check({name, "_bus"}, io.if_to_id_bus, {mem_word(pc), pc});
    check({name, "_addr"}, io.inst_sram_addr, addr);
  endtask

  initial begin
    int          br_left;
    logic [31:0] rdst;
    logic        ra, rb, rr;
    io.id_allowin     = 1'b0;
    io.id_to_if_brbus = '0;
    repeat (3) @(posedge clk);

    // Reset release, sequential fetch.
    drive(1, 1, 0, 0);
    check("rel_addr", io.inst_sram_addr, 32'h8000_0000);
    check("rel_valid", io.if_to_id_valid, 1'b0);
    drive(1, 1, 0, 0);
    check("first_bus", io.if_to_id_bus, {32'h9000_0000, 32'h8000_0000});
    expect_out("seq1", 1, 32'h8000_0000, 32'h8000_0004);
    drive(1, 1, 0, 0);
    expect_out("seq2", 1, 32'h8000_0004, 32'h8000_0008);

    // Three-cycle stall on pc 0x8000_0008.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      check("stall_bus", io.if_to_id_bus, {32'h9000_0008, 32'h8000_0008});
`ifdef IF_INST_BUF_EN
      check("stall_en", io.inst_sram_en, (i == 0));
`else
      check("stall_addr", io.inst_sram_addr, 32'h8000_0008);
`endif
    end
    drive(1, 1, 0, 0);
    expect_out("acc", 1, 32'h8000_0008, 32'h8000_000C);
    drive(1, 1, 0, 0);
    expect_out("after", 1, 32'h8000_000C, 32'h8000_0010);

    // One-cycle redirect squashes pc 0x8000_0010.
    drive(1, 1, 1, 32'h8000_0100);
    expect_out("br1", 0, 32'h0, 32'h8000_0100);
    drive(1, 1, 0, 0);
    expect_out("br1_tgt", 1, 32'h8000_0100, 32'h8000_0104);
    drive(1, 1, 0, 0);
    expect_out("br1_seq", 1, 32'h8000_0104, 32'h8000_0108);

    // Redirect held three cycles while ID stalls.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 32'h8000_0200);
      expect_out("brhold", 0, 32'h0, 32'h8000_0200);
    end
    drive(1, 0, 0, 0);
    check("brhold_tgt", io.if_to_id_bus, {32'h9000_0200, 32'h8000_0200});
    drive(1, 1, 0, 0);

    // Redirect to the top of memory: sequential PC wraps to zero.
    drive(1, 1, 1, 32'hFFFF_FFFC);
    check("wrap_a0", io.inst_sram_addr, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0);
    check("wrap_a1", io.inst_sram_addr, 32'h0000_0000);
    check("wrap_bus", io.if_to_id_bus, {32'h0FFF_FFFC, 32'hFFFF_FFFC});
    drive(1, 1, 0, 0);
    check("wrap_pc0", io.if_to_id_bus, {32'h1000_0000, 32'h0000_0000});

    // Reset in the middle of a stall (buffer full in the buffered build).
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", io.if_to_id_valid, 1'b0);
    check("midrst_en", io.inst_sram_en, 1'b0);
    drive(0, 0, 0, 0);
    drive(1, 1, 0, 0);
    check("rerel_addr", io.inst_sram_addr, 32'h8000_0000);
    check("rerel_en", io.inst_sram_en, 1'b1);
    drive(1, 1, 0, 0);
    check("rerel_bus", io.if_to_id_bus, {32'h9000_0000, 32'h8000_0000});
    check("rerel_valid", io.if_to_id_valid, 1'b1);

    // Randomized traffic; the per-cycle compare process checks it.
    br_left = 0;
    rdst    = 32'h8000_0000;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 199) != 0);
      ra = ($urandom_range(0, 9) < 6);
      if (br_left > 0) begin
        rb = 1'b1;
        br_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        rb      = 1'b1;
        br_left = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0:       rdst = $urandom;
          1:       rdst = 32'hFFFF_FFF8 + (32'($urandom_range(0, 1)) << 2);
          default: rdst = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
        endcase
      end else begin
        rb = 1'b0;
      end
      drive(rr, ra, rb, rdst);
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
